fft_bitrev_reorder: RTL and testbench

//  Output stage directly downstream of the 64-pt radix-2^2 SDF FFT core.
//  The core emits bins in bit-reversed order; this block buffers each N-sample frame in a

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_reorder_ram.sv | 37 +++
 rtl/fft_bitrev_reorder.sv | 160 ++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reordering stage.
//   clog2       : ceiling log2, used to size counters and addresses.
//   bit_reverse : reverses the low 'bits' bits of a value (bin <-> arrival order).
//   rd_state_e  : state encoding of the reorder buffer's read FSM.
package fft_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[i] = value[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM backing the ping-pong reorder buffer.
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           async active-low reset (clears only the read register)
//   wr_en_i/waddr_i/wdata_i   synchronous write port
//   rd_en_i/raddr_i           read request; data appears in rdata_o one cycle later
//   rdata_o          registered read data; holds its value when rd_en_i is low
// Memory contents are never cleared.
module fft_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rdata_q <= '0;
    else if (rd_en_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output stage behind the radix-2^2 SDF FFT core: buffers each N-sample frame,
// which arrives in bit-reversed bin order, in a ping-pong RAM and replays it in
// natural bin order as one gapless burst.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   enable_in, in_re, in_im input samples, bit-reversed order
//   enable_out, out_re/im   output samples, natural order
//   index_out               position within the output frame (0..N-1)
//   frame_done              pulse with the last sample of each burst
// Stream semantics: enable_in / enable_out mark a sample valid on that cycle.
// There is no ready/backpressure in either direction; every enabled sample is
// consumed, and the downstream must accept every enable_out cycle.
// Build option: FFT_REORDER_FFTSHIFT_EN replays each frame with the halves swapped
// (read address = rcnt ^ N/2) so DC lands in the middle; index_out stays 0..N-1.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int N     = 64,
  parameter  int WIDTH = 8,
  localparam int LOG2N = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0] index_out,
  output logic             frame_done
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  // Write side
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       full_set, full_clr;
  logic [LOG2N-1:0] waddr_rev;

  // Read side
  rd_state_e        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic [LOG2N-1:0] rcnt_addr;
  logic             rd_en;
  logic [1:0]       full_now;

  // Output stage (data comes straight from the RAM's read register)
  logic             en_q;
  logic [LOG2N-1:0] idx_q;
  logic             done_q;
  logic [2*WIDTH-1:0] rdata;

  assign waddr_rev = LOG2N'(bit_reverse(32'(wcnt_q), LOG2N));

  always_comb begin
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    full_set = '0;
    if (enable_in) begin
      if (wcnt_q == LAST) begin
        wcnt_d            = '0;
        wbank_d           = ~wbank_q;
        full_set[wbank_q] = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // A bank completed by the writer this very cycle counts as full for the
  // end-of-burst decision, so back-to-back frames chain with no idle cycle.
  assign full_now = full_q | full_set;

  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    rcnt_d   = rcnt_q;
    rd_en    = 1'b0;
    full_clr = '0;
    case (state_q)
      RD_IDLE: begin
        if (|full_q) begin
          state_d = RD_READ;
          // With both banks full the one the writer points at was filled first.
          rbank_d = full_q[wbank_q] ? wbank_q : ~wbank_q;
          rcnt_d  = '0;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if (rcnt_q == LAST) begin
          full_clr[rbank_q] = 1'b1;
          rcnt_d            = '0;
          if (full_now[~rbank_q]) rbank_d = ~rbank_q;
          else                    state_d = RD_IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign full_d = full_now & ~full_clr;

`ifdef FFT_REORDER_FFTSHIFT_EN
  assign rcnt_addr = rcnt_q ^ LOG2N'(N / 2);
`else
  assign rcnt_addr = rcnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      state_q <= RD_IDLE;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
      en_q    <= rd_en;
      if (rd_en) idx_q <= rcnt_q;
      done_q  <= rd_en && (rcnt_q == LAST);
    end
  end

  fft_reorder_ram #(
    .AW(LOG2N + 1),
    .DW(2 * WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wr_en_i (enable_in),
    .waddr_i ({wbank_q, waddr_rev}),
    .wdata_i ({in_re, in_im}),
    .rd_en_i (rd_en),
    .raddr_i ({rbank_q, rcnt_addr}),
    .rdata_o (rdata)
  );

  assign enable_out = en_q;
  assign out_re     = rdata[2*WIDTH-1:WIDTH];
  assign out_im     = rdata[WIDTH-1:0];
  assign index_out  = idx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=64, WIDTH=8).
// Build with +define+FFT_REORDER_FFTSHIFT_EN to check the DC-centred order.
module tb_fft_bitrev_reorder;

  localparam int N  = 64;
  localparam int W  = 8;
  localparam int LG = 6;
  localparam int EW = 2 * W + LG + 1;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = N / 2;
`else
  localparam int SHIFT = 0;
`endif

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_in = 1'b0;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          enable_out;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic [LG-1:0] index_out;
  logic          frame_done;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im),
    .index_out  (index_out),
    .frame_done (frame_done)
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  int run = 0;
  int last_run = 0;
  int last_in_cyc = 0;
  bit lat_arm = 1'b0;
  logic [W-1:0] fr_re [N];
  logic [W-1:0] fr_im [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bitrev6(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LG; i++) if (v[i]) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  // Output position k carries bin k^SHIFT, which arrived at position bitrev(bin).
  task automatic push_expected();
    int j;
    for (int k = 0; k < N; k++) begin
      j = bitrev6(k ^ SHIFT);
      exp_q.push_back({fr_re[j], fr_im[j], LG'(k), (k == N - 1)});
    end
  endtask

  // Monitor: compare every valid output against the head of the queue.
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done && !enable_out) chk("done_without_valid", 1, 0);
      if (enable_out) begin
        n_out++;
        run++;
        if (lat_arm) begin
          chk("first_out_latency", cyc - last_in_cyc, 2);
          lat_arm = 1'b0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_re",     out_re,     e[EW-1 -: W]);
          chk("out_im",     out_im,     e[W+LG -: W]);
          chk("index_out",  index_out,  e[LG:1]);
          chk("frame_done", frame_done, e[0]);
        end
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  // Driver tasks
  task automatic drive_sample(input logic [W-1:0] re, input logic [W-1:0] im);
    @(posedge clk);
    #1;
    enable_in = 1'b1;
    in_re     = re;
    in_im     = im;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      enable_in = 1'b0;
    end
  endtask

  // mode 0: re=j, im=255-j; mode 1: re=j, im=f; mode 2: random data.
  // gap 0: contiguous; 1: alternating idle; 2: random idle 0..3 cycles.
  task automatic send_frame(input int mode, input int f, input int gap, input int nsamp,
                            input bit arm);
    logic [W-1:0] re, im;
    for (int j = 0; j < nsamp; j++) begin
      case (mode)
        0:       begin re = W'(j); im = W'(255 - j); end
        1:       begin re = W'(j); im = W'(f); end
        default: begin re = W'($urandom_range(0, 255)); im = W'($urandom_range(0, 255)); end
      endcase
      fr_re[j] = re;
      fr_im[j] = im;
      if (j > 0 && gap == 1) drive_idle(1);
      if (j > 0 && gap == 2) drive_idle($urandom_range(0, 3));
      drive_sample(re, im);
      if (j == N - 1) begin
        last_in_cyc = cyc + 1;
        lat_arm     = arm;
        push_expected();
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_enable_out", enable_out, 0);
    chk("rst_index_out",  index_out,  0);
    chk("rst_out_re",     out_re,     0);
    exp_q.delete();
    lat_arm = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable_out", enable_out, 0);
    chk("reset_out_re",     out_re,     0);
    chk("reset_out_im",     out_im,     0);
    chk("reset_index_out",  index_out,  0);
    chk("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    drive_idle(3);

    // Single frame with latency check
    send_frame(0, 0, 0, N, 1'b1);
    drive_idle(1);
    wait_drain();
    chk("single_burst_len", last_run, N);

    // Three back-to-back frames: one gapless 192-sample burst
    send_frame(1, 0, 0, N, 1'b1);
    send_frame(1, 1, 0, N, 1'b0);
    send_frame(1, 2, 0, N, 1'b0);
    drive_idle(1);
    wait_drain();
    chk("b2b_burst_len", last_run, 3 * N);

    // Alternating-gap frame
    send_frame(0, 0, 1, N, 1'b1);
    drive_idle(1);
    wait_drain();
    chk("gapped_burst_len", last_run, N);

    // Random data, random gaps
    send_frame(2, 0, 2, N, 1'b1);
    drive_idle(1);
    wait_drain();

    // Reset at output index 20 aborts the burst
    send_frame(0, 0, 0, N, 1'b0);
    drive_idle(1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (enable_out && index_out == LG'(20)) found = 1'b1;
    end
    chk("index20_reached", found, 1);
    pulse_reset();
    n0 = n_out;
    drive_idle(80);
    chk("no_output_after_reset", n_out - n0, 0);
    send_frame(0, 0, 0, N, 1'b1);
    drive_idle(1);
    wait_drain();

    // Reset after a 30-sample partial frame, then one full new frame
    n0 = n_out;
    send_frame(2, 0, 0, 30, 1'b0);
    drive_idle(1);
    pulse_reset();
    send_frame(1, 7, 0, N, 1'b1);
    drive_idle(1);
    wait_drain();
    chk("post_partial_count", n_out - n0, N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
